isp_top: RTL and testbench
==========================

ISP_TOP -- requirements
Module: isp_top

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16: bits per color channel.
REQ-002 SHALL have parameter INT_BITS_CC, default 6: integer bits of each color-correction coefficient, excluding the PIXEL_WIDTH headroom.
REQ-003 SHALL have parameter FRAC_BITS_CC, default 6: fraction bits of each color-correction coefficient.
REQ-004 SHALL have parameter FRAC_BITS_WB, default 8: fraction bits of color_scale.
REQ-005 SHALL define CW = INT_BITS_CC+FRAC_BITS_CC+PIXEL_WIDTH (28 at defaults) as the coefficient width.
REQ-006 Ports SHALL be:
- clk  in  1: single clock, all logic on its rising edge.
- reset  in  1: asynchronous, active-low reset.
- new_frame  in  1: start-of-frame pulse.
- init_write_address  in  32: word address of the first output pixel.
- top_margin, left_margin  in  10 each: crop offsets, in rows and pixels.
- crop_height, crop_width  in  16 each: output frame size.
- color_scale  in  16: unsigned white-balance gain, FRAC_BITS_WB fraction bits.
- cblack  in  16: black level.
- cc_coeff  in  9*CW: signed 3x3 matrix, row-major, c00 in the MSBs.
- read_data  in  64: combinational memory read data.
- read_address  out  32: memory read address.
- write_enable  out  1: memory write strobe.
- write_address  out  32: memory write address.
- write_data  out  64: memory write data.
- done  out  1: frame complete.

Function
REQ-007 Memory words SHALL hold one pixel each: {16'h0, R[47:32], G[31:16], B[15:0]}; write_data SHALL use the same format, with bits [63:48] = 0.
REQ-008 Input stride SHALL be S = crop_width + 2*left_margin; pixel (x,y) SHALL be read from (top_margin+y)*S + left_margin + x, where x < crop_width and y < crop_height.
REQ-009 The row base address SHALL be formed by accumulating S once per row; no multiplier SHALL be used for addressing.
REQ-010 States SHALL be IDLE, RUN, DRAIN.
- IDLE->RUN on new_frame=1, latching all configuration inputs.
- RUN reads one pixel per cycle in raster order; it goes to DRAIN after the last pixel's read.
- DRAIN->IDLE once the last write has been issued.
- new_frame outside IDLE SHALL be ignored.
REQ-011 Black-level stage SHALL compute p = max(ch - cblack, 0) per channel.
REQ-012 White-balance stage SHALL compute q = min((p*color_scale) >> FRAC_BITS_WB, 2^PIXEL_WIDTH-1) per channel.
REQ-013 Color-correction stage SHALL compute out_i = sum over j of (cij * q_j), with q_j treated as unsigned, then arithmetic shift right by FRAC_BITS_CC, then clamp to [0, 2^PIXEL_WIDTH-1].
REQ-014 Pipeline SHALL be 4 registered stages (black, WB, CC, clamp); write_enable for a pixel SHALL assert exactly 4 cycles after the cycle in which its read_address is driven.
REQ-015 The k-th output pixel (raster index k) SHALL be written to init_write_address + k.
REQ-016 done SHALL pulse high for 1 cycle, in the cycle after the final write.
REQ-017 crop_width=0 or crop_height=0 SHALL produce no reads and no writes; done SHALL pulse 1 cycle after new_frame.
REQ-018 read_address SHALL hold its last value when not in RUN.

Reset
REQ-019 reset=0 SHALL immediately force state IDLE, and SHALL clear the pipeline valid bits, write_enable, done, write_address, read_address and write_data to 0.
REQ-020 Reset mid-frame SHALL abandon the frame; no further writes SHALL occur until the next new_frame.

Configuration
REQ-021 With macro ISP_CC_EN defined, the color-correction stage of REQ-013 SHALL be built.
REQ-022 Without ISP_CC_EN, the CC stage SHALL be a plain register passing q unchanged and cc_coeff SHALL be ignored; latency SHALL stay 4 cycles.

Verification
REQ-023 Identity: cij=64 on the diagonal, 0 elsewhere; color_scale=256; cblack=100; pixel {1000,2000,3000} -> write_data {0,900,1900,2900}.
REQ-024 Black clamp: cblack=100, R=50 -> output R=0.
REQ-025 WB saturate: color_scale=512, G=40000 -> output G=65535.
REQ-026 CC negative clamp: c00=64, c01=-128, others 0; RGB {100,100,0} -> output R=0.
REQ-027 Addressing: crop_width=4, crop_height=2, left_margin=1, top_margin=1, init_write_address=0x20000.
- Reads SHALL be 7,8,9,10,13,14,15,16.
- Writes SHALL go to 0x20000..0x20007.
- done SHALL pulse once after the last write.
REQ-028 Reset mid-frame: reset asserted after 3 writes -> write_enable=0 in the same cycle; no writes until the next new_frame.

Source files
------------

// File: rtl/isp_top.sv
// isp_top: streaming ISP pixel pipeline. Reads a cropped window one pixel
// per cycle, applies black level, white balance and an optional 3x3 colour
// matrix, and writes the frame out to a linear destination buffer.
// Build option: define ISP_CC_EN to build the colour-correction matrix;
// without it the CC stage is a plain register and cc_coeff is ignored.
module isp_top #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int INT_BITS_CC  = 6,
  parameter int FRAC_BITS_CC = 6,
  parameter int FRAC_BITS_WB = 8,
  localparam int CW = INT_BITS_CC + FRAC_BITS_CC + PIXEL_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            new_frame,
  input  logic [31:0]     init_write_address,
  input  logic [9:0]      top_margin,
  input  logic [9:0]      left_margin,
  input  logic [15:0]     crop_height,
  input  logic [15:0]     crop_width,
  input  logic [15:0]     color_scale,
  input  logic [15:0]     cblack,
  input  logic [9*CW-1:0] cc_coeff,
  input  logic [63:0]     read_data,
  output logic [31:0]     read_address,
  output logic            write_enable,
  output logic [31:0]     write_address,
  output logic [63:0]     write_data,
  output logic            done
);

  localparam int PW  = PIXEL_WIDTH;
  localparam int SW  = CW + PW + 3;   // signed CC accumulator width
  localparam int WBW = PW + 16;       // white-balance product width
  localparam logic [PW-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_reg, state_next;

  // latched frame configuration
  logic [9:0]  left_reg;
  logic [15:0] width_reg, height_reg, scale_reg, cblack_reg;
  logic [31:0] stride_reg;

  // raster scan state
  logic [31:0] row_base_reg;
  logic [15:0] x_reg, y_reg;
  logic [9:0]  top_cnt_reg;
  logic        rd_valid_reg;
  logic [31:0] wr_ptr_reg;

  // pipeline, channels packed {R,G,B}
  logic            s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [3*PW-1:0] s1_next, s1_pix_reg, s2_next, s2_pix_reg, s4_next;
  logic [3*SW-1:0] s3_next, s3_val_reg;

  logic issue_read, skip_row, done_next, start_frame, last_pixel, pipe_busy;

  assign last_pixel = (x_reg == width_reg - 16'd1) && (y_reg == height_reg - 16'd1);
  assign pipe_busy  = rd_valid_reg | s1_valid_reg | s2_valid_reg | s3_valid_reg;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state and control strobes; the top margin is skipped by
  // accumulating the stride once per skipped row before reading starts
  always_comb begin
    state_next  = state_reg;
    issue_read  = 1'b0;
    skip_row    = 1'b0;
    done_next   = 1'b0;
    start_frame = 1'b0;
    case (state_reg)
      IDLE: begin
        if (new_frame) begin
          if (crop_width == 16'd0 || crop_height == 16'd0) begin
            done_next = 1'b1;
          end else begin
            start_frame = 1'b1;
            state_next  = RUN;
          end
        end
      end
      RUN: begin
        if (top_cnt_reg != 10'd0) begin
          skip_row = 1'b1;
        end else begin
          issue_read = 1'b1;
          if (last_pixel) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (write_enable && !pipe_busy) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // configuration capture at frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_reg   <= '0;
      width_reg  <= '0;
      height_reg <= '0;
      scale_reg  <= '0;
      cblack_reg <= '0;
      stride_reg <= '0;
    end else if (start_frame) begin
      left_reg   <= left_margin;
      width_reg  <= crop_width;
      height_reg <= crop_height;
      scale_reg  <= color_scale;
      cblack_reg <= cblack;
      stride_reg <= 32'(crop_width) + 32'({left_margin, 1'b0});
    end
  end

  // raster address generation: row base accumulates the stride per row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_base_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      top_cnt_reg  <= '0;
      rd_valid_reg <= 1'b0;
      read_address <= '0;
    end else begin
      rd_valid_reg <= issue_read;
      if (start_frame) begin
        row_base_reg <= '0;
        x_reg        <= '0;
        y_reg        <= '0;
        top_cnt_reg  <= top_margin;
      end else if (skip_row) begin
        row_base_reg <= row_base_reg + stride_reg;
        top_cnt_reg  <= top_cnt_reg - 10'd1;
      end else if (issue_read) begin
        read_address <= row_base_reg + 32'(left_reg) + 32'(x_reg);
        if (x_reg == width_reg - 16'd1) begin
          x_reg        <= '0;
          y_reg        <= y_reg + 16'd1;
          row_base_reg <= row_base_reg + stride_reg;
        end else begin
          x_reg <= x_reg + 16'd1;
        end
      end
    end
  end

`ifdef ISP_CC_EN
  logic [9*CW-1:0] coeff_reg;

  // colour matrix capture at frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           coeff_reg <= '0;
    else if (start_frame) coeff_reg <= cc_coeff;
  end
`else
  logic unused_cc;
  assign unused_cc = ^cc_coeff;
`endif

  logic unused_hi;
  assign unused_hi = ^read_data[63:3*PW];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      localparam int LO = (2 - gi) * PW;
      localparam int SO = (2 - gi) * SW;

      // black level: subtract and floor at zero
      logic [PW-1:0] ch;
      logic [31:0]   ch_w, cb_w;
      assign ch   = read_data[LO +: PW];
      assign ch_w = 32'(ch);
      assign cb_w = 32'(cblack_reg);
      assign s1_next[LO +: PW] = (ch_w > cb_w) ? PW'(ch_w - cb_w) : '0;

      // white balance: fixed-point gain with saturation
      logic [WBW-1:0] wb_prod, wb_shift;
      assign wb_prod  = WBW'(s1_pix_reg[LO +: PW]) * WBW'(scale_reg);
      assign wb_shift = wb_prod >> FRAC_BITS_WB;
      assign s2_next[LO +: PW] = (wb_shift > WBW'(PIX_MAX)) ? PIX_MAX : wb_shift[PW-1:0];

`ifdef ISP_CC_EN
      logic signed [SW-1:0] acc;
      // colour matrix row: signed coefficients times unsigned channels
      always_comb begin
        acc = '0;
        for (int j = 0; j < 3; j++) begin
          acc = acc + SW'($signed(coeff_reg[(8 - (gi * 3 + j)) * CW +: CW]))
                    * SW'($signed({1'b0, s2_pix_reg[(2 - j) * PW +: PW]}));
        end
      end
      assign s3_next[SO +: SW] = acc >>> FRAC_BITS_CC;
`else
      assign s3_next[SO +: SW] = SW'(s2_pix_reg[LO +: PW]);
`endif

      // final clamp of the signed CC result into the pixel range
      logic [SW-1:0] s3_ch;
      assign s3_ch = s3_val_reg[SO +: SW];
      assign s4_next[LO +: PW] = s3_ch[SW-1]        ? '0 :
                                 (|s3_ch[SW-2:PW])  ? PIX_MAX :
                                 s3_ch[PW-1:0];
    end
  endgenerate

  // four-stage pixel pipeline and the write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s1_pix_reg    <= '0;
      s2_pix_reg    <= '0;
      s3_val_reg    <= '0;
      write_enable  <= 1'b0;
      write_data    <= '0;
      write_address <= '0;
      wr_ptr_reg    <= '0;
      done          <= 1'b0;
    end else begin
      s1_valid_reg <= rd_valid_reg;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      s1_pix_reg   <= s1_next;
      s2_pix_reg   <= s2_next;
      s3_val_reg   <= s3_next;
      write_enable <= s3_valid_reg;
      done         <= done_next;
      if (s3_valid_reg) begin
        write_data    <= 64'(s4_next);
        write_address <= wr_ptr_reg;
        wr_ptr_reg    <= wr_ptr_reg + 32'd1;
      end
      if (start_frame) wr_ptr_reg <= init_write_address;
    end
  end

endmodule

// File: tb/tb_isp_top.sv
// tb_isp_top: self-checking bench for isp_top with a behavioural pixel
// model and a combinational memory model.
module tb_isp_top;
  localparam int CW = 28;

  logic            clk = 1'b0;
  logic            reset, new_frame;
  logic [31:0]     init_write_address;
  logic [9:0]      top_margin, left_margin;
  logic [15:0]     crop_height, crop_width, color_scale, cblack;
  logic [9*CW-1:0] cc_coeff;
  logic [63:0]     read_data;
  logic [31:0]     read_address, write_address;
  logic            write_enable, done;
  logic [63:0]     write_data;

  logic [63:0] mem [0:1023];
  int coef [3][3];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign read_data = mem[read_address[9:0]];

  isp_top dut (
    .clk(clk), .reset(reset), .new_frame(new_frame),
    .init_write_address(init_write_address),
    .top_margin(top_margin), .left_margin(left_margin),
    .crop_height(crop_height), .crop_width(crop_width),
    .color_scale(color_scale), .cblack(cblack), .cc_coeff(cc_coeff),
    .read_data(read_data), .read_address(read_address),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .done(done)
  );

  // transaction monitor, sampled on the falling edge
  int          cyc = 0;
  int          nf_cyc = -1;
  logic [31:0] ra_hist [16];
  logic [31:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  logic [31:0] wr_ra_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (write_enable === 1'b1) begin
      wr_addr_q.push_back(write_address);
      wr_data_q.push_back(write_data);
      wr_ra_q.push_back(ra_hist[4'(cyc - 4)]);
      wr_cyc_q.push_back(cyc);
      $display("  write addr=%08h data=%016h", write_address, write_data);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
    if (new_frame === 1'b1) nf_cyc = cyc;
    ra_hist[4'(cyc)] = read_address;
  end

  // reference pixel: black level, gain, optional matrix, clamp
  function automatic logic [63:0] model_pixel(input logic [63:0] w);
    longint p, s;
    longint q [3];
    longint o [3];
    for (int c = 0; c < 3; c++) begin
      p = longint'(w[(2 - c) * 16 +: 16]) - longint'(cblack);
      if (p < 0) p = 0;
      q[c] = (p * longint'(color_scale)) / 256;
      if (q[c] > 65535) q[c] = 65535;
    end
`ifdef ISP_CC_EN
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int j = 0; j < 3; j++) s += longint'(coef[i][j]) * q[j];
      s = s >>> 6;
      if (s < 0) s = 0;
      if (s > 65535) s = 65535;
      o[i] = s;
    end
`else
    for (int i = 0; i < 3; i++) o[i] = q[i];
`endif
    return {16'h0, 16'(o[0]), 16'(o[1]), 16'(o[2])};
  endfunction

  task automatic set_coeff();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        cc_coeff[(8 - (i * 3 + j)) * CW +: CW] = CW'(coef[i][j]);
  endtask

  task automatic identity_coeff();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        coef[i][j] = (i == j) ? 64 : 0;
    set_coeff();
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_ra_q.delete();
    wr_cyc_q.delete(); done_cyc_q.delete(); nf_cyc = -1;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    clear_log();
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cyc_q.size() > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (2) begin @(negedge clk); #1; end
  endtask

  task automatic config_frame(input int w, input int h, input int top, input int left,
                              input logic [31:0] init);
    crop_width = 16'(w); crop_height = 16'(h);
    top_margin = 10'(top); left_margin = 10'(left);
    init_write_address = init;
  endtask

  task automatic test_reset();
    reset = 1'b0; new_frame = 1'b0;
    config_frame(1, 1, 0, 0, 32'h0);
    color_scale = 16'd256; cblack = 16'd0;
    identity_coeff();
    for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
    #2;
    n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", write_enable); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (read_address !== 32'h0) begin n_fail++; $display("FAIL reset_ra got=%h exp=0", read_address); end
    n_checks++; if (write_address !== 32'h0) begin n_fail++; $display("FAIL reset_wa got=%h exp=0", write_address); end
    n_checks++; if (write_data !== 64'h0) begin n_fail++; $display("FAIL reset_wd got=%h exp=0", write_data); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // single-pixel frame with a fixed expected word
  task automatic one_pixel(input string name, input logic [63:0] pix, input logic [63:0] exp);
    bit to;
    config_frame(1, 1, 0, 0, 32'h100);
    mem[0] = pix;
    start_frame();
    wait_done(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL %s_timeout got=no_done exp=done", name); end
    n_checks++; if (wr_data_q.size() != 1) begin n_fail++; $display("FAIL %s_count got=%0d exp=1", name, wr_data_q.size()); end
    if (wr_data_q.size() >= 1) begin
      n_checks++; if (wr_data_q[0] !== exp) begin n_fail++; $display("FAIL %s_data got=%h exp=%h", name, wr_data_q[0], exp); end
      n_checks++; if (wr_addr_q[0] !== 32'h100) begin n_fail++; $display("FAIL %s_addr got=%h exp=100", name, wr_addr_q[0]); end
      n_checks++; if (wr_ra_q[0] !== 32'h0) begin n_fail++; $display("FAIL %s_latency_ra got=%h exp=0", name, wr_ra_q[0]); end
    end
  endtask

  task automatic test_identity();
    identity_coeff(); color_scale = 16'd256; cblack = 16'd100;
    one_pixel("identity", {16'h0, 16'd1000, 16'd2000, 16'd3000}, 64'h0000_0384_076C_0B54);
  endtask

  task automatic test_black_clamp();
    identity_coeff(); color_scale = 16'd256; cblack = 16'd100;
    one_pixel("black_clamp", {16'h0, 16'd50, 16'd500, 16'd150}, 64'h0000_0000_0190_0032);
  endtask

  task automatic test_wb_saturate();
    identity_coeff(); color_scale = 16'd512; cblack = 16'd0;
    one_pixel("wb_sat", {16'h0, 16'd1000, 16'd40000, 16'd20000}, 64'h0000_07D0_FFFF_9C40);
  endtask

  task automatic test_cc_negative();
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) coef[i][j] = 0;
    coef[0][0] = 64; coef[0][1] = -128;
    set_coeff();
    color_scale = 16'd256; cblack = 16'd0;
`ifdef ISP_CC_EN
    exp = 64'h0;
`else
    exp = 64'h0000_0064_0064_0000;
`endif
    one_pixel("cc_neg", {16'h0, 16'd100, 16'd100, 16'd0}, exp);
  endtask

  task automatic test_addressing();
    bit to;
    int exp_rd [8] = '{7, 8, 9, 10, 13, 14, 15, 16};
    identity_coeff(); color_scale = 16'd256; cblack = 16'd0;
    for (int i = 0; i < 1024; i++) mem[i] = {16'h0, 16'($urandom), 16'($urandom), 16'($urandom)};
    config_frame(4, 2, 1, 1, 32'h20000);
    start_frame();
    wait_done(100, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL addr_timeout got=no_done exp=done"); end
    n_checks++; if (wr_addr_q.size() != 8) begin n_fail++; $display("FAIL addr_count got=%0d exp=8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      n_checks++; if (wr_ra_q[k] !== 32'(exp_rd[k])) begin n_fail++; $display("FAIL addr_read[%0d] got=%0d exp=%0d", k, wr_ra_q[k], exp_rd[k]); end
      n_checks++; if (wr_addr_q[k] !== 32'h20000 + 32'(k)) begin n_fail++; $display("FAIL addr_write[%0d] got=%h exp=%h", k, wr_addr_q[k], 32'h20000 + 32'(k)); end
      n_checks++; if (wr_data_q[k] !== model_pixel(mem[exp_rd[k]])) begin n_fail++; $display("FAIL addr_data[%0d] got=%h exp=%h", k, wr_data_q[k], model_pixel(mem[exp_rd[k]])); end
      n_checks++; if (wr_cyc_q[k] != wr_cyc_q[0] + k) begin n_fail++; $display("FAIL addr_rate[%0d] got=%0d exp=%0d", k, wr_cyc_q[k], wr_cyc_q[0] + k); end
    end
    n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL addr_done_count got=%0d exp=1", done_cyc_q.size()); end
    if (done_cyc_q.size() >= 1 && wr_cyc_q.size() >= 1) begin
      n_checks++; if (done_cyc_q[0] != wr_cyc_q[wr_cyc_q.size() - 1] + 1) begin n_fail++; $display("FAIL addr_done_cycle got=%0d exp=%0d", done_cyc_q[0], wr_cyc_q[wr_cyc_q.size() - 1] + 1); end
    end
    repeat (3) begin @(negedge clk); #1; end
    n_checks++; if (read_address !== 32'd16) begin n_fail++; $display("FAIL addr_hold got=%0d exp=16", read_address); end
  endtask

  task automatic test_empty();
    bit to;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) config_frame(0, 3, 1, 1, 32'h500);
      else        config_frame(5, 0, 0, 2, 32'h600);
      start_frame();
      wait_done(20, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL empty%0d_timeout got=no_done exp=done", t); end
      n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL empty%0d_writes got=%0d exp=0", t, wr_addr_q.size()); end
      n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL empty%0d_done_count got=%0d exp=1", t, done_cyc_q.size()); end
      if (done_cyc_q.size() >= 1) begin
        n_checks++; if (done_cyc_q[0] != nf_cyc + 1) begin n_fail++; $display("FAIL empty%0d_done_cycle got=%0d exp=%0d", t, done_cyc_q[0], nf_cyc + 1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int w, h, top, left, s, k, ea;
    logic [31:0] init;
    for (int f = 0; f < 6; f++) begin
      w = $urandom_range(1, 6); h = $urandom_range(1, 4);
      top = $urandom_range(0, 3); left = $urandom_range(0, 3);
      init = $urandom & 32'h00FF_FFF0;
      color_scale = 16'($urandom_range(0, 1024));
      cblack = 16'($urandom_range(0, 4000));
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) coef[i][j] = int'($urandom_range(0, 320)) - 128;
      set_coeff();
      for (int i = 0; i < 1024; i++) mem[i] = {16'h0, 16'($urandom), 16'($urandom), 16'($urandom)};
      config_frame(w, h, top, left, init);
      $display("  frame %0d: %0dx%0d top=%0d left=%0d init=%08h", f, w, h, top, left, init);
      start_frame();
      wait_done(200, to);
      s = w + 2 * left;
      n_checks++; if (to) begin n_fail++; $display("FAIL b2b%0d_timeout got=no_done exp=done", f); end
      n_checks++; if (wr_addr_q.size() != w * h) begin n_fail++; $display("FAIL b2b%0d_count got=%0d exp=%0d", f, wr_addr_q.size(), w * h); end
      n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL b2b%0d_done_count got=%0d exp=1", f, done_cyc_q.size()); end
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          k = y * w + x;
          ea = (top + y) * s + left + x;
          if (k < wr_addr_q.size()) begin
            n_checks++; if (wr_ra_q[k] !== 32'(ea)) begin n_fail++; $display("FAIL b2b%0d_read[%0d] got=%0d exp=%0d", f, k, wr_ra_q[k], ea); end
            n_checks++; if (wr_addr_q[k] !== init + 32'(k)) begin n_fail++; $display("FAIL b2b%0d_write[%0d] got=%h exp=%h", f, k, wr_addr_q[k], init + 32'(k)); end
            n_checks++; if (wr_data_q[k] !== model_pixel(mem[ea])) begin n_fail++; $display("FAIL b2b%0d_data[%0d] got=%h exp=%h", f, k, wr_data_q[k], model_pixel(mem[ea])); end
          end
        end
      end
    end
  endtask

  task automatic test_ignore_new_frame();
    bit to;
    identity_coeff(); color_scale = 16'd256; cblack = 16'd0;
    config_frame(4, 2, 0, 0, 32'h300);
    start_frame();
    @(posedge clk); #1;
    new_frame = 1'b1; init_write_address = 32'h999; crop_width = 16'd1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    wait_done(100, to);
    repeat (10) begin @(negedge clk); #1; end
    n_checks++; if (to) begin n_fail++; $display("FAIL ignore_nf_timeout got=no_done exp=done"); end
    n_checks++; if (wr_addr_q.size() != 8) begin n_fail++; $display("FAIL ignore_nf_count got=%0d exp=8", wr_addr_q.size()); end
    n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL ignore_nf_done got=%0d exp=1", done_cyc_q.size()); end
    for (int k = 0; k < wr_addr_q.size(); k++) begin
      n_checks++; if (wr_addr_q[k] !== 32'h300 + 32'(k)) begin n_fail++; $display("FAIL ignore_nf_addr[%0d] got=%h exp=%h", k, wr_addr_q[k], 32'h300 + 32'(k)); end
    end
  endtask

  task automatic test_reset_mid();
    bit reached, to;
    identity_coeff(); color_scale = 16'd256; cblack = 16'd0;
    config_frame(8, 2, 0, 0, 32'h400);
    start_frame();
    reached = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (wr_addr_q.size() >= 3) begin reached = 1'b1; break; end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL rst_mid_reach got=%0d exp=3", wr_addr_q.size()); end
    reset = 1'b0;
    #1;
    n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we got=%b exp=0", write_enable); end
    n_checks++; if (read_address !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ra got=%h exp=0", read_address); end
    n_checks++; if (write_address !== 32'h0) begin n_fail++; $display("FAIL rst_mid_wa got=%h exp=0", write_address); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (30) begin @(negedge clk); #1; end
    n_checks++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL rst_mid_writes got=%0d exp=3", wr_addr_q.size()); end
    n_checks++; if (done_cyc_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_done got=%0d exp=0", done_cyc_q.size()); end
    config_frame(2, 1, 0, 0, 32'h700);
    start_frame();
    wait_done(50, to);
    n_checks++; if (to || wr_addr_q.size() != 2) begin n_fail++; $display("FAIL rst_recover got=%0d writes exp=2", wr_addr_q.size()); end
    if (wr_addr_q.size() == 2) begin
      n_checks++; if (wr_addr_q[1] !== 32'h701) begin n_fail++; $display("FAIL rst_recover_addr got=%h exp=701", wr_addr_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_black_clamp();
    test_wb_saturate();
    test_cc_negative();
    test_addressing();
    test_empty();
    test_back_to_back();
    test_ignore_new_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
